eval_operand_feeder: RTL
========================

Name: eval_operand_feeder

Overview:
- Upstream stage of eval_module. Buffers operand pairs from a producer in a small FIFO with a valid/ready handshake.
- Issues one operand pair per cycle as registered data_in1/data_in2/kernel_enable.
- When idle, holds its outputs stable and forces kernel_enable low, so the ROM-add path downstream sees no toggling (gating-friendly).
- Generates result_valid aligned with eval_module's 1-cycle registered result.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- WIDTH, 8, operand width; must match eval_module data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  producer has an operand pair
- in_ready  out  1  feeder can accept; equals (count < DEPTH)
- in_data1  in  WIDTH  operand 1; low 4 bits are the ROM address downstream
- in_data2  in  WIDTH  operand 2; inverted downstream
- in_kernel  in  1  per-entry kernel request
- hold  in  1  downstream stall; blocks issue
- flush  in  1  discard all buffered entries
- data_in1  out  WIDTH  registered operand 1 to eval_module
- data_in2  out  WIDTH  registered operand 2 to eval_module
- kernel_enable  out  1  registered; high only on issue cycles of kernel entries
- issue_valid  out  1  data_in*/kernel_enable hold a new pair this cycle
- result_valid  out  1  eval_module.result is valid this cycle (issue_valid delayed 1)
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- idle  out  1  count==0 and issue_valid==0 and result_valid==0

Behaviour:
- Reset (rst high at posedge), all registers cleared:
  - data_in1, data_in2 = 0; kernel_enable = 0; issue_valid = 0; result_valid = 0.
  - count = 0; read/write pointers = 0; state = IDLE.
  - in_ready = 1 combinationally after reset. rst overrides flush, push and pop.
- Reset mid-operation drops all entries and any in-flight result_valid. No partial issue survives.
- Push: at posedge when in_valid && in_ready. Stores {in_kernel, in_data2, in_data1} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop/issue: at posedge when count>0 && !hold && !flush.
  - Entry at rd_ptr is loaded into data_in1/data_in2, and kernel_enable := stored kernel bit.
  - issue_valid := 1; rd_ptr wraps modulo DEPTH.
- No issue at a posedge:
  - issue_valid := 0 and kernel_enable := 0.
  - data_in1/data_in2 hold their previous values (no toggling).
- Simultaneous push and pop: count unchanged.
- in_ready is computed from the current count only, so a full FIFO refuses a push even when a pop occurs in the same cycle.
- No bypass: an entry pushed at edge k is issued no earlier than edge k+1. Push-to-issue_valid latency is 2 cycles from in_valid sampling.
- result_valid := issue_valid, registered each cycle. It is not affected by hold, because eval_module registers every cycle.
- flush at posedge:
  - count := 0 and rd_ptr := wr_ptr.
  - issue_valid := 0 and kernel_enable := 0.
  - A push in the same cycle is dropped.
  - result_valid still follows the prior issue_valid.
- State machine (reported for debug only; behaviour is defined by the rules above):
  - IDLE (count==0) -> RUN on push.
  - RUN -> STALL when hold && count>0.
  - STALL -> RUN when !hold.
  - RUN/STALL -> IDLE when count reaches 0 or on flush.
- Widths: count saturates by construction at DEPTH; overflow and underflow are impossible. The bench must assert count never exceeds DEPTH.

Test Plan:
- Reset then single entry: push (in_data1=5, in_data2=0x10, in_kernel=1).
  - Expect issue_valid=1 two cycles after push with kernel_enable=1.
  - One cycle later, result_valid=1 and eval result = 17+0xEF+5 = 0x05.
- Non-kernel entry: push (3, 0xFF, 0).
  - Expect kernel_enable=0 on issue and result = 0+3 = 0x03 with result_valid.
  - data_in1 must hold at 3 on subsequent idle cycles.
- Fill and backpressure: hold=1, push 5 entries back-to-back.
  - Expect in_ready=0 after 4 accepted, count=4, 5th not accepted.
  - Release hold: 4 issues on consecutive cycles in push order, with pointers wrapping.
- Simultaneous push/pop at count=2 for 6 cycles.
  - Expect count stays 2 and issue order equals push order.
  - result_valid is a 1-cycle-delayed copy of issue_valid.
- Flush with count=3 and push asserted in the same cycle.
  - Expect count=0, in_ready=1, no issue_valid next cycle.
  - The pushed entry is discarded; idle=1 within 2 cycles.
- rst pulse while count=3 and issue_valid=1.
  - Next cycle all outputs are 0 and count=0.
  - No result_valid pulse follows the reset.

Source files
------------

// File: rtl/eval_operand_feeder.sv
// Operand-pair FIFO feeding eval_module: one registered issue per cycle, quiet outputs
// when idle, and result_valid aligned with eval_module's one-cycle registered result.
module eval_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data1,
  input  logic [WIDTH-1:0]           in_data2,
  input  logic                       in_kernel,
  input  logic                       hold,
  input  logic                       flush,
  output logic [WIDTH-1:0]           data_in1,
  output logic [WIDTH-1:0]           data_in2,
  output logic                       kernel_enable,
  output logic                       issue_valid,
  output logic                       result_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STALL} state_t;

  typedef struct packed {
    logic             kernel;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d1;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_next;
  logic            push, pop;
  state_t          state, state_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    in_ready   = (count < CW'(DEPTH));
    push       = in_valid && in_ready && !flush;
    pop        = (count != '0) && !hold && !flush;
    count_next = count;
    if (flush) count_next = '0;
    else       count_next = count + CW'(push) - CW'(pop);
    idle       = (count == '0) && !issue_valid && !result_valid;
  end

  // Debug-only state; it tracks occupancy and never steers the datapath.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (push) state_next = ST_RUN;
      ST_RUN:   if (flush || count_next == '0) state_next = ST_IDLE;
                else if (hold)                 state_next = ST_STALL;
      ST_STALL: if (flush || count_next == '0) state_next = ST_IDLE;
                else if (!hold)                state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{kernel: in_kernel, d2: in_data2, d1: in_data1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      state         <= ST_IDLE;
      data_in1      <= '0;
      data_in2      <= '0;
      kernel_enable <= 1'b0;
      issue_valid   <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      count        <= count_next;
      state        <= state_next;
      result_valid <= issue_valid;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (flush) rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (pop) begin
        data_in1      <= mem[rd_ptr].d1;
        data_in2      <= mem[rd_ptr].d2;
        kernel_enable <= mem[rd_ptr].kernel;
        issue_valid   <= 1'b1;
      end else begin
        // Operands hold their last value so the downstream ROM-add path stays quiet.
        kernel_enable <= 1'b0;
        issue_valid   <= 1'b0;
      end
    end
  end

  a_state_tracks_count: assert property (@(posedge clk) disable iff (rst)
    (state == ST_IDLE) == (count == '0));

endmodule
